// File: rtl/hoops_pkg.sv
// hoops_pkg
// Shared constants and types for the hoop game blocks: screen geometry,
// hoop sprite size and the spawn scheduler FSM state encoding.
package hoops_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int HOOP_W   = 28;
    localparam int HOOP_H   = 58;
    localparam int LFSR_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_ISSUE = 2'd2
    } hoop_state_e;

endpackage

// File: rtl/lfsr16.sv
// lfsr16
// 16-bit Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1.
// Shifts left one position per enabled clock; the new LSB is the XOR of
// the tap bits. Only the low OUT_W bits are exported.
//
// Ports:
//   clk     system clock
//   resetN  asynchronous, active-high reset (loads SEED)
//   enable  advance the register this cycle
//   value   low OUT_W bits of the register
module lfsr16
    import hoops_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
    parameter int                OUT_W = LFSR_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             enable,
    output logic [OUT_W-1:0] value
);

    logic [LFSR_W-1:0] state;
    logic              feedback;

    // Taps 16,14,13,11 counted from 1 map to bits 15,13,12,10.
    assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state <= SEED;
        end else if (enable) begin
            state <= {state[LFSR_W-2:0], feedback};
        end
    end

    assign value = state[OUT_W-1:0];

endmodule

// File: rtl/hoop_spawn_scheduler.sv
// hoop_spawn_scheduler
// Counts video frames and, once per SPAWN_PERIOD frames, hands a new hoop
// to the lowest-index free mover slot at a pseudo-random X position.
//
// Ports:
//   clk           system clock
//   resetN        asynchronous, active-high reset (name kept from codebase)
//   startOfFrame  one-cycle pulse per video frame
//   pause         freezes frame counting and the LFSR
//   slotRetire    per-slot pulse: hoop left the screen or hit the tower
//   spawnAck      mover accepted the pending spawn command
//   spawnValid    spawn command pending (high exactly in ISSUE)
//   spawnSlot     target slot index, held until acked
//   spawnX        signed spawn X in pixels, 0..X_RANGE-1, held until acked
//   slotBusy      1 = slot holds a live hoop
//   slotCollect   (HOOP_SCORE_EN) per-slot tower-through-hoop pulse
//   score         (HOOP_SCORE_EN) saturating 16-bit collect counter
//
// Build option: define HOOP_SCORE_EN to add slotCollect/score.
module hoop_spawn_scheduler
    import hoops_pkg::*;
#(
    parameter int          NUM_SLOTS    = 4,
    parameter int          SPAWN_PERIOD = 90,
    parameter int          X_RANGE      = SCREEN_W - HOOP_W,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic                         pause,
    input  logic [NUM_SLOTS-1:0]         slotRetire,
    input  logic                         spawnAck,
`ifdef HOOP_SCORE_EN
    input  logic [NUM_SLOTS-1:0]         slotCollect,
    output logic [15:0]                  score,
`endif
    output logic                         spawnValid,
    output logic [$clog2(NUM_SLOTS)-1:0] spawnSlot,
    output logic signed [10:0]           spawnX,
    output logic [NUM_SLOTS-1:0]         slotBusy
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int CNT_W  = $clog2(SPAWN_PERIOD);

    localparam logic [1:0]       IDLE      = ST_IDLE;
    localparam logic [1:0]       PICK      = ST_PICK;
    localparam logic [1:0]       ISSUE     = ST_ISSUE;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SPAWN_PERIOD - 1);
    localparam logic [10:0]      X_RANGE_U = 11'(X_RANGE);

    logic [1:0]           state;
    logic [CNT_W-1:0]     frame_cnt;
    logic                 spawnPending;
    logic [9:0]           lfsr_low;
    logic                 period_wrap;
    logic                 ack_take;
    logic                 free_found;
    logic [SLOT_W-1:0]    free_idx;
    logic [NUM_SLOTS-1:0] set_mask;

    // Fold a 10-bit random value (0..1023) into 0..X_RANGE-1 with one
    // conditional subtract; valid because X_RANGE is at least 512.
    function automatic logic signed [10:0] fold_x(input logic [9:0] l);
        logic [10:0] lx;
        lx = {1'b0, l};
        if (lx >= X_RANGE_U) begin
            return $signed(lx - X_RANGE_U);
        end
        return $signed(lx);
    endfunction

    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (10)
    ) u_lfsr (
        .clk    (clk),
        .resetN (resetN),
        .enable (!pause),
        .value  (lfsr_low)
    );

    assign period_wrap = startOfFrame && !pause && (frame_cnt == CNT_LAST);
    assign ack_take    = (state == ISSUE) && spawnAck;
    assign spawnValid  = (state == ISSUE);

    // Lowest-index free slot: scan downwards so the last hit wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slotBusy[i]) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        set_mask = '0;
        if (ack_take) begin
            set_mask[spawnSlot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            frame_cnt <= '0;
        end else if (startOfFrame && !pause) begin
            frame_cnt <= period_wrap ? '0 : frame_cnt + CNT_W'(1);
        end
    end

    // Pending is a flag, not a count: a wrap while already pending is absorbed.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            spawnPending <= 1'b0;
        end else if (ack_take) begin
            spawnPending <= 1'b0;
        end else if (period_wrap) begin
            spawnPending <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            state     <= IDLE;
            spawnSlot <= '0;
            spawnX    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (spawnPending) begin
                        state <= PICK;
                    end
                end
                PICK: begin
                    // No free slot: back to IDLE with pending still set,
                    // which retries PICK on the following cycle.
                    if (free_found) begin
                        spawnSlot <= free_idx;
                        spawnX    <= fold_x(lfsr_low);
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (spawnAck) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A same-cycle ack set beats a retire clear on the same slot.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            slotBusy <= '0;
        end else begin
            slotBusy <= (slotBusy & ~slotRetire) | set_mask;
        end
    end

`ifdef HOOP_SCORE_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // One point per cycle regardless of how many busy slots collected.
    always_ff @(posedge clk or posedge resetN) begin
        if (resetN) begin
            score <= '0;
        end else if (|(slotCollect & slotBusy)) begin
            score <= sat_inc16(score);
        end
    end
`endif

endmodule

// File: tb/tb_hoop_spawn_scheduler.sv
module tb_hoop_spawn_scheduler;

    localparam int NS     = 4;
    localparam int FAST_P = 3;
    localparam int XR     = 612;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    logic                a_sof, a_pause, a_ack;
    logic [3:0]          a_retire;
    logic                a_valid;
    logic [1:0]          a_slot;
    logic signed [10:0]  a_x;
    logic [3:0]          a_busy;

    logic                b_sof, b_pause, b_ack;
    logic [3:0]          b_retire;
    logic                b_valid;
    logic [1:0]          b_slot;
    logic signed [10:0]  b_x;
    logic [3:0]          b_busy;

`ifdef HOOP_SCORE_EN
    logic [3:0]  a_collect, b_collect;
    logic [15:0] a_score, b_score;
`endif

    hoop_spawn_scheduler dut_a (
        .clk          (clk),
        .resetN       (rst_a),
        .startOfFrame (a_sof),
        .pause        (a_pause),
        .slotRetire   (a_retire),
        .spawnAck     (a_ack),
`ifdef HOOP_SCORE_EN
        .slotCollect  (a_collect),
        .score        (a_score),
`endif
        .spawnValid   (a_valid),
        .spawnSlot    (a_slot),
        .spawnX       (a_x),
        .slotBusy     (a_busy)
    );

    hoop_spawn_scheduler #(.SPAWN_PERIOD(FAST_P)) dut_b (
        .clk          (clk),
        .resetN       (rst_b),
        .startOfFrame (b_sof),
        .pause        (b_pause),
        .slotRetire   (b_retire),
        .spawnAck     (b_ack),
`ifdef HOOP_SCORE_EN
        .slotCollect  (b_collect),
        .score        (b_score),
`endif
        .spawnValid   (b_valid),
        .spawnSlot    (b_slot),
        .spawnX       (b_x),
        .slotBusy     (b_busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       sof;
        logic [3:0] retire;
        logic       ack;
        logic       exp_valid;
        logic [1:0] exp_slot;
        logic [3:0] exp_busy;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_true(input string name, input logic cond);
        check(name, int'(cond), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR: polynomial x^16+x^14+x^13+x^11+1, shift toward MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic int fold(input int l);
        return (l >= XR) ? l - XR : l;
    endfunction

    function automatic int lowest_free(input logic [3:0] b);
        for (int i = 0; i < NS; i++) if (!b[i]) return i;
        return -1;
    endfunction

    task automatic reset_b();
        rst_b = 1'b1;
        b_sof = 0; b_pause = 0; b_ack = 0; b_retire = '0;
        tick(); tick();
        check("b_reset_valid", int'(b_valid), 0);
        check("b_reset_busy", int'(b_busy), 0);
        rst_b = 1'b0;
    endtask

    task automatic a_wait_spawn(input string name, input int exp_slot);
        int n;
        n = 0;
        a_ack = 0;
        a_sof = 1;
        while (!a_valid && n < 400) begin
            tick();
            n++;
        end
        a_sof = 0;
        check_true({name, "_arrive"}, a_valid);
        if (a_valid) check(name, int'(a_slot), exp_slot);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int vcnt, vslot, n;
        int s0, x0;
        logic [15:0] tlfsr, pick_val;
        logic prev_v;
        int exp_x;
        logic [15:0] m_lfsr, prev_lfsr;
        logic [3:0] m_busy, prev_busy, r;
        logic m_pend, m_issuing, accepted, wrap;
        int m_frames, m_slot, m_x, stall, es;
        int spawns, distinct, xi;
        bit seen[XR];

        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000};
        tbl[6]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001};
        tbl[7]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[9]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[11] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[12] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0000};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0001};
        tbl[16] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001};
        tbl[18] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001};
        tbl[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0001};
        tbl[20] = '{1'b0, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0001};
        tbl[21] = '{1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 4'b0011};
        tbl[22] = '{1'b0, 4'b0011, 1'b0, 1'b0, 2'd0, 4'b0000};

        rst_a = 1'b1; rst_b = 1'b1;
        a_sof = 0; a_pause = 0; a_ack = 0; a_retire = '0;
        b_sof = 0; b_pause = 0; b_ack = 0; b_retire = '0;
`ifdef HOOP_SCORE_EN
        a_collect = '0; b_collect = '0;
`endif
        tick(); tick();
        check("a_reset_valid", int'(a_valid), 0);
        check("a_reset_slot", int'(a_slot), 0);
        check("a_reset_x", int'(a_x), 0);
        check("a_reset_busy", int'(a_busy), 0);
`ifdef HOOP_SCORE_EN
        check("a_reset_score", int'(a_score), 0);
`endif
        rst_a = 1'b0;

        // 90 frames with ack tied high: exactly one single-cycle spawn to slot 0
        a_ack = 1;
        vcnt = 0; vslot = -1;
        for (int k = 0; k < 90; k++) begin
            a_sof = 1; tick();
            if (a_valid) begin vcnt++; vslot = int'(a_slot); end
            a_sof = 0; tick();
            if (a_valid) begin vcnt++; vslot = int'(a_slot); end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_valid) begin vcnt++; vslot = int'(a_slot); end
        end
        check("first_spawn_cycles", vcnt, 1);
        check("first_spawn_slot", vslot, 0);
        check("first_spawn_busy", int'(a_busy), 1);
        a_ack = 0;

        // fill remaining slots in index order
        for (int s = 1; s < NS; s++) begin
            a_wait_spawn("fill_slot", s);
            a_ack = 1; tick(); a_ack = 0;
        end
        check("all_busy", int'(a_busy), 15);

        // period wraps while full: no spawn; retire slot 2 -> spawn within 3 cycles
        vcnt = 0;
        a_sof = 1;
        for (int k = 0; k < 100; k++) begin
            if (k == 90) a_sof = 0;
            tick();
            if (a_valid) vcnt++;
        end
        check("full_no_spawn", vcnt, 0);
        a_retire = 4'b0100; tick(); a_retire = '0;
        n = 1;
        while (!a_valid && n < 3) begin tick(); n++; end
        check_true("retry_spawn_valid", a_valid);
        check("retry_spawn_slot", int'(a_slot), 2);

        // hold ISSUE unacked while pause toggles
        s0 = int'(a_slot); x0 = int'(a_x);
        check_true("hold_x_range", x0 >= 0 && x0 < XR);
        for (int k = 0; k < 50; k++) begin
            a_pause = ~a_pause;
            tick();
            check("hold_valid", int'(a_valid), 1);
            check("hold_slot", int'(a_slot), s0);
            check("hold_x", int'(a_x), x0);
        end
        a_pause = 0; a_ack = 1; tick(); a_ack = 0;
        check("hold_ack_valid", int'(a_valid), 0);
        check("hold_ack_busy", int'(a_busy), 15);

`ifdef HOOP_SCORE_EN
        a_collect = 4'b0001; tick();
        a_collect = 4'b1000; tick();
        a_collect = 4'b0010; tick();
        a_collect = 4'b0000;
        a_retire = 4'b0100; tick(); a_retire = '0;
        a_collect = 4'b0100; tick();
        a_collect = 4'b0000; tick();
        check("score_value", int'(a_score), 3);
        check("score_busy", int'(a_busy), 4'b1011);
`endif

        // reset in ISSUE drops valid without a clock edge and discards the command
        a_retire = 4'b0010; tick(); a_retire = '0;
        a_wait_spawn("reset_issue_slot", 1);
        #2;
        rst_a = 1'b1;
        #1;
        check("reset_async_valid", int'(a_valid), 0);
        check("reset_async_busy", int'(a_busy), 0);
        check("reset_async_slot", int'(a_slot), 0);
        check("reset_async_x", int'(a_x), 0);
        tick();
        rst_a = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_valid) vcnt++;
        end
        check("reset_discard", vcnt, 0);

        // table-driven sequence on the short-period instance
        reset_b();
        tlfsr = SEED; prev_v = 0; exp_x = 0;
        foreach (tbl[i]) begin
            b_sof = tbl[i].sof; b_retire = tbl[i].retire; b_ack = tbl[i].ack; b_pause = 0;
            pick_val = tlfsr;
            tlfsr = lfsr_step(tlfsr);
            tick();
            check($sformatf("tbl%0d_valid", i), int'(b_valid), int'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_busy", i), int'(b_busy), int'(tbl[i].exp_busy));
            if (tbl[i].exp_valid) begin
                if (!prev_v) exp_x = fold(int'(pick_val[9:0]));
                check($sformatf("tbl%0d_slot", i), int'(b_slot), int'(tbl[i].exp_slot));
                check($sformatf("tbl%0d_x", i), int'(b_x), exp_x);
            end
            prev_v = tbl[i].exp_valid;
        end
        b_sof = 0; b_retire = '0; b_ack = 0;

        // randomized traffic against the reference model
        reset_b();
        m_lfsr = SEED; m_busy = '0; m_pend = 0; m_issuing = 0;
        m_frames = 0; m_slot = 0; m_x = 0; stall = 0;
        for (int c = 0; c < 3000; c++) begin
            b_sof   = ($urandom_range(0, 1) == 1);
            b_pause = ($urandom_range(0, 3) == 0);
            b_ack   = ($urandom_range(0, 2) == 0);
            r = '0;
            for (int i = 0; i < NS; i++) if ($urandom_range(0, 7) == 0) r[i] = 1'b1;
            b_retire = r;

            accepted  = m_issuing && b_ack;
            prev_busy = m_busy;
            prev_lfsr = m_lfsr;
            wrap = 0;
            if (b_sof && !b_pause) begin
                m_frames++;
                if (m_frames % FAST_P == 0) wrap = 1;
            end
            if (!b_pause) m_lfsr = lfsr_step(m_lfsr);
            if (accepted) m_pend = 0;
            else if (wrap) m_pend = 1;
            m_busy = (m_busy & ~b_retire) | (accepted ? (4'b0001 << m_slot) : 4'b0000);

            tick();
            check("rnd_busy", int'(b_busy), int'(m_busy));
            if (accepted) begin
                check("rnd_ack_drop", int'(b_valid), 0);
                m_issuing = 0;
            end else if (m_issuing) begin
                check("rnd_hold_valid", int'(b_valid), 1);
                check("rnd_hold_slot", int'(b_slot), m_slot);
                check("rnd_hold_x", int'(b_x), m_x);
            end else if (b_valid) begin
                es = lowest_free(prev_busy);
                check("rnd_spawn_pending", int'(m_pend), 1);
                check("rnd_spawn_slot", int'(b_slot), es);
                m_x = fold(int'(prev_lfsr[9:0]));
                check("rnd_spawn_x", int'(b_x), m_x);
                m_slot = (es < 0) ? 0 : es;
                m_issuing = 1;
                stall = 0;
            end else begin
                if (m_pend && m_busy != 4'hF) stall++;
                else stall = 0;
                if (m_pend) check_true("rnd_spawn_latency", stall <= 3);
                if (stall > 3) stall = 0;
            end
        end

        // long run: ack tied high, slots retired right away
        reset_b();
        spawns = 0; distinct = 0;
        foreach (seen[i]) seen[i] = 0;
        b_sof = 1; b_pause = 0; b_ack = 1;
        for (int c = 0; c < 20000 && spawns < 1000; c++) begin
            b_retire = b_busy;
            tick();
            if (b_valid) begin
                spawns++;
                xi = int'(b_x);
                check_true("x_in_range", xi >= 0 && xi < XR);
                if (xi >= 0 && xi < XR && !seen[xi]) begin
                    seen[xi] = 1;
                    distinct++;
                end
            end
        end
        b_sof = 0; b_ack = 0; b_retire = '0;
        check("spawn_count", spawns, 1000);
        check_true("x_distinct_16", distinct >= 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
